// File: rtl/frame_buffer_ram.sv
// frame_buffer_ram: single-clock pixel RAM with write-first read bypass, 1- or 2-cycle read latency and optional clear engine
// Optional feature macro: FB_CLEAR_EN compiles in the full-memory clear engine.
// Ports:
//   clk                 rising-edge clock for all state
//   reset               synchronous active-high reset (RAM contents untouched)
//   wr_valid/wr_ready   write handshake; wr_addr/wr_data written when both high
//   rd_en/rd_addr       read request; rd_data/rd_valid appear RD_LAT cycles later
//   clear_req           start writing CLEAR_VAL to every address
//   busy                clear in progress (write port blocked)
module frame_buffer_ram #(
    parameter int AW = 19,
    parameter int DW = 12,
    parameter int RD_LAT = 1,
    parameter logic [DW-1:0] CLEAR_VAL = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    input  logic          clear_req,
    output logic          busy
);
    localparam int NPOS = 2 ** AW;
    logic [DW-1:0] ram [NPOS];
    logic          clr_act;
    logic [AW-1:0] clr_cnt;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_data;
    logic [DW-1:0] rd_word;
    logic          s1_valid;
    logic [DW-1:0] s1_data;
`ifdef FB_CLEAR_EN
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t        state, state_nxt;
    logic [AW-1:0] cnt_nxt;
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= cnt_nxt;
        end
    end
    // the all-ones counter value marks the last address of the sweep
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        state_nxt = (state == IDLE) ? (clear_req ? CLEAR : IDLE) : (&clr_cnt ? IDLE : CLEAR);
        cnt_nxt   = (state == CLEAR) ? clr_cnt + 1'b1 : '0;
    end
    assign clr_act  = (state == CLEAR);
    assign busy     = clr_act;
    assign wr_ready = !clr_act;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
    assign clr_act  = 1'b0;
    assign clr_cnt  = '0;
    assign busy     = 1'b0;
    assign wr_ready = 1'b1;
`endif
    // clear and user writes share the single write port; they never coincide since wr_ready=0 while clearing
    assign w_en   = !reset && (clr_act || (wr_valid && wr_ready));
    assign w_addr = clr_act ? clr_cnt : wr_addr;
    assign w_data = clr_act ? CLEAR_VAL : wr_data;
    always_ff @(posedge clk) begin
        if (w_en) ram[w_addr] <= w_data;
    end
    // write-first: a same-cycle write to the read address is forwarded
    assign rd_word = (w_en && w_addr == rd_addr) ? w_data : ram[rd_addr];
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_en;
            if (rd_en) s1_data <= rd_word;
        end
    end
    generate
        if (RD_LAT == 2) begin : g_lat2
            logic          s2_valid;
            logic [DW-1:0] s2_data;
            always_ff @(posedge clk) begin
                if (reset) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid) s2_data <= s1_data;
                end
            end
            assign rd_valid = s2_valid;
            assign rd_data  = s2_data;
        end else begin : g_lat1
            assign rd_valid = s1_valid;
            assign rd_data  = s1_data;
        end
    endgenerate
endmodule

// File: doc/frame_buffer_ram.md
FRAME_BUFFER_RAM -- requirements
Module: frame_buffer_ram

Interface
REQ-001 SHALL have parameter AW, default 19, address width in bits; depth NPOS = 2**AW.
REQ-002 SHALL have parameter DW, default 12, pixel data width in bits.
REQ-003 SHALL have parameter RD_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 SHALL have parameter CLEAR_VAL, default 0 (DW bits), the value the clear engine writes.
REQ-005 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port wr_valid  input  1  write request.
REQ-008 SHALL have port wr_ready  output  1  write port can accept.
REQ-009 SHALL have port wr_addr  input  AW  write address.
REQ-010 SHALL have port wr_data  input  DW  write data.
REQ-011 SHALL have port rd_en  input  1  read request.
REQ-012 SHALL have port rd_addr  input  AW  read address.
REQ-013 SHALL have port rd_data  output  DW  registered read data.
REQ-014 SHALL have port rd_valid  output  1  rd_data holds a new result this cycle.
REQ-015 SHALL have port clear_req  input  1  start full-memory clear.
REQ-016 SHALL have port busy  output  1  clear in progress.

Function
REQ-017 Write SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1; ram[wr_addr] updated at that edge.
REQ-018 wr_valid while wr_ready=0 SHALL be dropped; no write, no queueing.
REQ-019 rd_en=1 at edge N SHALL produce rd_data=ram[rd_addr] and rd_valid=1 after edge N+RD_LAT-1 (visible for the cycle after it), i.e. RD_LAT cycles after the request cycle.
REQ-020 rd_valid SHALL be 1 for exactly one cycle per request; back-to-back reads SHALL yield one result per cycle, in order.
REQ-021 rd_data SHALL hold its last value while rd_valid=0.
REQ-022 Read and accepted write to the same address in the same cycle SHALL return the new write data (write-first bypass); different addresses are independent.
REQ-023 Clear FSM SHALL have states IDLE and CLEAR; IDLE -> CLEAR on clear_req=1; CLEAR -> IDLE after the write to address NPOS-1.
REQ-024 In CLEAR, an AW-bit counter SHALL start at 0 and write CLEAR_VAL to one address per cycle, incrementing by 1; the clear takes exactly NPOS cycles.
REQ-025 busy SHALL be 1 and wr_ready SHALL be 0 in every CLEAR cycle; both SHALL revert (busy=0, wr_ready=1) the cycle after the last clear write.
REQ-026 clear_req asserted while in CLEAR SHALL be ignored (no restart).
REQ-027 Reads SHALL be served during CLEAR; same-cycle read of the address being cleared SHALL return CLEAR_VAL (bypass per REQ-022).
REQ-028 In IDLE with clear_req=1 and wr_valid=1 on the same edge, the write SHALL be accepted and the clear SHALL start next cycle (overwriting it).

Reset
REQ-029 reset=1 SHALL force on the next edge: FSM=IDLE, clear counter=0, busy=0, wr_ready=1, rd_valid=0, rd_data=0, read pipeline emptied.
REQ-030 reset SHALL NOT alter RAM contents; reset mid-clear SHALL abort the clear, leaving partially cleared contents.
REQ-031 reset SHALL take priority over clear_req, wr_valid and rd_en in the same cycle.

Configuration
REQ-032 Macro FB_CLEAR_EN SHALL compile the clear engine in; with it defined, REQ-023..REQ-028 apply.
REQ-033 Without FB_CLEAR_EN, clear_req SHALL be ignored, busy SHALL be tied 0, wr_ready SHALL be tied 1, and no FSM or counter logic SHALL be present.

Verification (AW=4, DW=12, CLEAR_VAL=12'h000, FB_CLEAR_EN defined unless stated)
REQ-034 Write 12'hABC @5, then rd_en @5 -> rd_data=12'hABC with rd_valid high exactly RD_LAT cycles later; repeat for RD_LAT=1 and 2.
REQ-035 Same-cycle write 12'h123 and read @7 -> rd_data=12'h123 (write-first).
REQ-036 Fill all 16 addresses with 12'hFFF, pulse clear_req -> busy=1 for 16 cycles, wr_ready=0 throughout, a write during CLEAR dropped; afterwards all reads return 12'h000.
REQ-037 reset asserted on the 8th clear cycle -> busy=0 next cycle; addresses 0-6 read 12'h000, addresses 8-15 read 12'hFFF.
REQ-038 Streaming rd_en on addresses 0..15 for 16 cycles -> 16 consecutive rd_valid pulses with data in address order.
REQ-039 Build without FB_CLEAR_EN, pulse clear_req -> busy stays 0, wr_ready stays 1, memory contents unchanged.
